counter: RTL and testbench



---
 rtl/counter_if.sv | 33 +++
 rtl/counter.sv | 71 +++++++
 tb/tb_counter.sv | 111 +++++++++++
 3 files changed

// File: rtl/counter_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_if
// Description : Push/pop request and occupancy status bundle for counter.
//               Error-flag signals exist only with COUNTER_ERR_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_if #(
    parameter int WIDTH = 3
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] cnt;
    logic             full;
    logic             empty;
`ifdef COUNTER_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;

    modport master (output push, output pop,
                    input cnt, input full, input empty,
                    input overflow, input underflow);
    modport slave  (input push, input pop,
                    output cnt, output full, output empty,
                    output overflow, output underflow);
`else
    modport master (output push, output pop,
                    input cnt, input full, input empty);
    modport slave  (input push, input pop,
                    output cnt, output full, output empty);
`endif
endinterface
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module      : counter
// Description : Saturating up/down occupancy counter with full/empty decode.
//               Define COUNTER_ERR_FLAGS_EN for sticky overflow/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7
) (
    input  wire logic  clk,
    input  wire logic  reset,
    counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max  = (r_cnt == c_max);
    assign w_at_zero = (r_cnt == c_zero);

`ifdef COUNTER_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;
`endif

    // Simultaneous push and pop is a no-op and never raises an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= c_zero;
`ifdef COUNTER_ERR_FLAGS_EN
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
`endif
        end else begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (!w_at_max)
                        r_cnt <= r_cnt + 1'b1;
`ifdef COUNTER_ERR_FLAGS_EN
                    else
                        r_overflow <= 1'b1;
`endif
                end
                2'b01: begin
                    if (!w_at_zero)
                        r_cnt <= r_cnt - 1'b1;
`ifdef COUNTER_ERR_FLAGS_EN
                    else
                        r_underflow <= 1'b1;
`endif
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.cnt   = r_cnt;
    assign bus.full  = w_at_max;
    assign bus.empty = w_at_zero;
`ifdef COUNTER_ERR_FLAGS_EN
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter
// Description : Directed self-checking bench for counter (WIDTH=3, MAX=7).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter;
    localparam int WIDTH = 3;
    localparam int MAX   = 7;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    counter_if #(.WIDTH(WIDTH)) bus ();

    counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic step(input logic r, input logic p, input logic q);
        reset    = r;
        bus.push = p;
        bus.pop  = q;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int c, input int ovf, input int unf);
        check({tag, ".cnt"},   int'(bus.cnt), c);
        check({tag, ".full"},  int'(bus.full), (c == MAX) ? 1 : 0);
        check({tag, ".empty"}, int'(bus.empty), (c == 0) ? 1 : 0);
`ifdef COUNTER_ERR_FLAGS_EN
        check({tag, ".ovf"},   int'(bus.overflow), ovf);
        check({tag, ".unf"},   int'(bus.underflow), unf);
`endif
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        @(negedge clk);

        // reset, then underflow at empty
        step(1, 0, 0); expect_state("rst",     0, 0, 0);
        step(0, 1, 0); expect_state("push1",   1, 0, 0);
        step(0, 0, 1); expect_state("pop1",    0, 0, 0);
        step(0, 0, 1); expect_state("pop_unf", 0, 0, 1);
        step(0, 0, 0); expect_state("idle",    0, 0, 1);

        // stepping up and down
        step(1, 0, 0); expect_state("rst2", 0, 0, 0);
        step(0, 1, 0); expect_state("up1", 1, 0, 0);
        step(0, 1, 0); expect_state("up2", 2, 0, 0);
        step(0, 1, 0); expect_state("up3", 3, 0, 0);
        step(0, 0, 1); expect_state("dn2", 2, 0, 0);
        step(0, 0, 1); expect_state("dn1", 1, 0, 0);

        // saturation at MAX
        step(1, 0, 0); expect_state("rst3", 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            step(0, 1, 0);
            expect_state($sformatf("sat%0d", i), (i < MAX) ? i : MAX, (i > MAX) ? 1 : 0, 0);
        end

        // push and pop together hold, no flags, at 0, 3 and 7
        step(1, 0, 0); expect_state("rst4", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1); expect_state("both0", 0, 0, 0);
        end
        for (int i = 1; i <= 3; i++) step(0, 1, 0);
        expect_state("at3", 3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1); expect_state("both3", 3, 0, 0);
        end
        for (int i = 4; i <= 7; i++) step(0, 1, 0);
        expect_state("at7", 7, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1); expect_state("both7", 7, 0, 0);
        end

        // set overflow, drop to 5, then reset while pushing
        step(0, 1, 0); expect_state("ovf7", 7, 1, 0);
        step(0, 0, 1); expect_state("to6",  6, 1, 0);
        step(0, 0, 1); expect_state("to5",  5, 1, 0);
        step(1, 1, 0); expect_state("rst_push", 0, 0, 0);
        step(0, 1, 0); expect_state("rel_push", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
